// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared Keccak lane types, FSM encoding and lane rotate helper
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int IDX_W     = 5;

    typedef logic [LANE_W-1:0] lane_t;
    typedef logic [IDX_W-1:0]  lane_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        THETA,
        EMIT,
        FLUSH
    } state_t;

    function automatic lane_t rol1(input lane_t v);
        return {v[LANE_W-2:0], v[LANE_W-1]};
    endfunction

endpackage

// File: rtl/theta_d_calc.sv
// rtl/theta_d_calc.sv - combinational theta column mix C[0..4] -> D[0..4]
module theta_d_calc
    import keccak_pkg::*;
(
    input  logic [4:0][LANE_W-1:0] c,
    output logic [4:0][LANE_W-1:0] d
);

    for (genvar x = 0; x < 5; x++) begin : g_d
        assign d[x] = c[(x + 4) % 5] ^ rol1(c[(x + 1) % 5]);
    end

endmodule

// File: rtl/theta_lane_streamer.sv
// rtl/theta_lane_streamer.sv - loads 25 lanes, applies theta, streams lanes then pulses writeToFile
module theta_lane_streamer
    import keccak_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] lane_in,
    output logic              ldn,
    output logic [IDX_W-1:0]  number,
    output logic [LANE_W-1:0] nIn,
    output logic              writeToFile,
    output logic              busy,
    output logic              done
);

    state_t                  state;
    lane_t                   laneBuf [NUM_LANES];
    logic [4:0][LANE_W-1:0]  parC;
    logic [4:0][LANE_W-1:0]  thetaD;
    logic [4:0][LANE_W-1:0]  dNext;
    lane_idx_t               laneCnt;
    logic [2:0]              xCnt;
    logic [2:0]              yCnt;
    logic                    accept;
    logic                    lastLane;

    theta_d_calc u_theta_d_calc (
        .c (parC),
        .d (dNext)
    );

    assign accept   = (state == LOAD) && in_valid && in_ready;
    assign lastLane = (xCnt == 3'd4) && (yCnt == 3'd4);
    assign busy     = (state != IDLE);

    // Lane storage is deliberately left unreset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept) begin
            laneBuf[laneCnt] <= lane_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            ldn         <= 1'b0;
            number      <= '0;
            nIn         <= '0;
            writeToFile <= 1'b0;
            done        <= 1'b0;
            laneCnt     <= '0;
            xCnt        <= '0;
            yCnt        <= '0;
            parC        <= '0;
            thetaD      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ldn         <= 1'b0;
                    writeToFile <= 1'b0;
                    done        <= 1'b0;
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        parC     <= '0;
                        laneCnt  <= '0;
                        xCnt     <= '0;
                        yCnt     <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        parC[xCnt] <= parC[xCnt] ^ lane_in;
                        if (lastLane) begin
                            laneCnt  <= '0;
                            xCnt     <= '0;
                            yCnt     <= '0;
                            in_ready <= 1'b0;
                            state    <= THETA;
                        end else begin
                            laneCnt <= laneCnt + 1'b1;
                            if (xCnt == 3'd4) begin
                                xCnt <= '0;
                                yCnt <= yCnt + 1'b1;
                            end else begin
                                xCnt <= xCnt + 1'b1;
                            end
                        end
                    end
                end
                THETA: begin
                    thetaD <= dNext;
                    state  <= EMIT;
                end
                EMIT: begin
                    ldn    <= 1'b1;
                    number <= laneCnt;
                    nIn    <= laneBuf[laneCnt] ^ thetaD[xCnt];
                    if (lastLane) begin
                        laneCnt <= '0;
                        xCnt    <= '0;
                        yCnt    <= '0;
                        state   <= FLUSH;
                    end else begin
                        laneCnt <= laneCnt + 1'b1;
                        if (xCnt == 3'd4) begin
                            xCnt <= '0;
                            yCnt <= yCnt + 1'b1;
                        end else begin
                            xCnt <= xCnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    ldn         <= 1'b0;
                    writeToFile <= 1'b1;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_theta_lane_streamer.sv
// tb/tb_theta_lane_streamer.sv - directed scoreboard bench for theta_lane_streamer
module tb_theta_lane_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] lane_in;
    logic        ldn;
    logic [4:0]  number;
    logic [63:0] nIn;
    logic        writeToFile;
    logic        busy;
    logic        done;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] stim   [25];
    logic [63:0] expTab [25];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          wtfCount = 0;
    int          wtfCyc   = -1;
    int          firstLdn = -1;
    int          lastAcc  = 0;

    theta_lane_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lane_in     (lane_in),
        .ldn         (ldn),
        .number      (number),
        .nIn         (nIn),
        .writeToFile (writeToFile),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (ldn) begin
                chk("ldn_with_empty_scoreboard", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("number", 64'(number), 64'(e.idx));
                    chk($sformatf("nIn[%0d]", e.idx), nIn, e.val);
                end
                if (number === 5'd0 && firstLdn < 0) firstLdn = cyc;
            end
            if (writeToFile) begin
                wtfCount++;
                wtfCyc = cyc;
                chk("done_with_writeToFile", 64'(done), 64'd1);
            end
        end
    end

    task automatic modelFill();
        logic [63:0] c [5];
        logic [63:0] d [5];
        for (int x = 0; x < 5; x++) c[x] = '0;
        for (int i = 0; i < 25; i++) c[i % 5] ^= stim[i];
        for (int x = 0; x < 5; x++)
            d[x] = c[(x + 4) % 5] ^ {c[(x + 1) % 5][62:0], c[(x + 1) % 5][63]};
        for (int i = 0; i < 25; i++) expTab[i] = stim[i] ^ d[i % 5];
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_ldn"}, 64'(ldn), 64'd0);
        chk({tag, "_number"}, 64'(number), 64'd0);
        chk({tag, "_nIn"}, nIn, 64'd0);
        chk({tag, "_writeToFile"}, 64'(writeToFile), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic loadState(input bit toggle);
        wtfCount = 0;
        firstLdn = -1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 25; i++) begin
            chk("in_ready_in_load", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            lane_in  = stim[i];
            @(posedge clk); #1;
            if (toggle && i < 24) begin
                in_valid = 1'b0;
                lane_in  = ~stim[i];
                chk("in_ready_in_gap", 64'(in_ready), 64'd1);
                @(posedge clk); #1;
            end
        end
        lastAcc  = cyc;
        in_valid = 1'b0;
        chk("in_ready_after_load", 64'(in_ready), 64'd0);
        chk("busy_in_theta", 64'(busy), 64'd1);
        for (int i = 0; i < 25; i++) sb.push_back('{idx: 5'(i), val: expTab[i]});
    endtask

    task automatic finishRun(input string tag, input bit startInEmit);
        if (startInEmit) begin
            repeat (8) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int k = 0; k < 60 && wtfCount == 0; k++) @(negedge clk);
        chk({tag, "_wtf_seen"}, 64'(wtfCount), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_wtf_count"}, 64'(wtfCount), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        chk({tag, "_wtf_latency"}, 64'(wtfCyc - lastAcc), 64'd27);
        chk({tag, "_first_lane_latency"}, 64'(firstLdn - lastAcc), 64'd2);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready_idle"}, 64'(in_ready), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        lane_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 25; i++) stim[i] = '0;
        modelFill();
        loadState(1'b0);
        finishRun("zero", 1'b0);

        for (int i = 0; i < 25; i++) begin
            stim[i]   = '0;
            expTab[i] = '0;
        end
        stim[0] = 64'h1;
        expTab[0] = 64'h1;
        for (int y = 0; y < 5; y++) begin
            expTab[1 + 5 * y] = 64'h1;
            expTab[4 + 5 * y] = 64'h2;
        end
        loadState(1'b0);
        finishRun("single_bit", 1'b0);

        for (int i = 0; i < 25; i++) begin
            stim[i]   = '0;
            expTab[i] = '0;
        end
        stim[3] = 64'h8000_0000_0000_0000;
        for (int y = 0; y < 5; y++) begin
            expTab[2 + 5 * y] = 64'h1;
            expTab[4 + 5 * y] = 64'h8000_0000_0000_0000;
        end
        expTab[3] = 64'h8000_0000_0000_0000;
        loadState(1'b0);
        finishRun("msb_wrap", 1'b0);

        for (int i = 0; i < 25; i++) stim[i] = {$urandom, $urandom};
        modelFill();
        loadState(1'b1);
        finishRun("toggle_valid", 1'b0);

        for (int i = 0; i < 25; i++) stim[i] = {$urandom, $urandom};
        modelFill();
        in_valid = 1'b1;
        lane_in  = 64'hDEAD_BEEF_0BAD_F00D;
        repeat (4) @(posedge clk);
        loadState(1'b0);
        finishRun("start_in_emit", 1'b1);

        for (int i = 0; i < 25; i++) stim[i] = {$urandom, $urandom};
        modelFill();
        loadState(1'b0);
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 40 && !hit; k++) begin
                @(negedge clk);
                if (ldn && number === 5'd10) hit = 1'b1;
            end
            chk("reached_lane10", 64'(hit), 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("abort");
        sb.delete();
        wtfCount = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_writeToFile", 64'(wtfCount), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 25; i++) stim[i] = {$urandom, $urandom};
        modelFill();
        loadState(1'b0);
        finishRun("after_abort", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
